spi_reg_bridge: RTL and testbench
=================================

Name: spi_reg_bridge

Overview:
- Command decoder and register-bus master that sits directly downstream of the SPI slave byte engine.
- Consumes received bytes (rx_data/rx_valid) and interprets each chip-select frame as a command byte followed by data bytes.
- Issues single-beat reads and writes on a simple req/ack register bus.
- Supplies the next byte to shift out (tx_data) so the host can stream register contents back.

Parameters:
- DATA_WIDTH, 8, SPI word width; fixed framing assumes 8.
- ADDR_WIDTH, 7, register address width (DATA_WIDTH-1).
- TIMEOUT, 16, max clk cycles to wait for reg_ack before abort.
- STATUS_ID, 7'h2A, identity code returned in the status byte.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cs_active  in  1  high while the frame is active, already synchronised to clk
- rx_data  in  DATA_WIDTH  received byte from SPI slave
- rx_valid  in  1  one-cycle pulse, rx_data valid
- tx_data  out  DATA_WIDTH  byte to shift out on the next SPI word
- reg_addr  out  ADDR_WIDTH  register bus address
- reg_wdata  out  DATA_WIDTH  write data
- reg_wr  out  1  write request, held until ack
- reg_rd  out  1  read request, held until ack
- reg_ack  in  1  one-cycle completion pulse
- reg_rdata  in  DATA_WIDTH  read data, valid with reg_ack
- err  out  1  sticky error flag
- byte_cnt  out  8  bytes received in the current frame, saturating at 255

Behaviour:
- Reset values:
  - state=IDLE, tx_data={1'b0,STATUS_ID}.
  - reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0.
  - err=0, byte_cnt=0.
- Command byte format: bit7=R/W (1=read), bits6:0=start address.
- States: IDLE, CMD, WR_WAIT, WR_BUS, RD_BUS, RD_STREAM.
- IDLE:
  - tx_data={err,STATUS_ID}.
  - cs_active rising (0→1 versus the previous cycle) → CMD, byte_cnt=0.
- CMD, on rx_valid: latch address into reg_addr, byte_cnt+1.
  - Write command → WR_WAIT.
  - Read command → assert reg_rd, go to RD_BUS.
- WR_WAIT, on rx_valid: reg_wdata=rx_data, assert reg_wr, go to WR_BUS.
- WR_BUS, on reg_ack:
  - drop reg_wr the same cycle the ack is seen (registered, so low on the next cycle);
  - reg_addr+1, go to WR_WAIT.
- RD_BUS, on reg_ack:
  - tx_data=reg_rdata, drop reg_rd, go to RD_STREAM.
- RD_STREAM, on rx_valid (host clocked out the byte; rx_data is ignored):
  - reg_addr+1, assert reg_rd, go to RD_BUS.
- Latency: a bus request is asserted exactly 1 clk after the qualifying rx_valid.
  - The host must allow ≥ bus latency + 2 clk between bytes.
- Address wrap: 7'h7F+1 → 7'h00, no error.
- Timeout:
  - A counter runs while in WR_BUS or RD_BUS and reloads on entry.
  - If TIMEOUT cycles elapse without reg_ack: drop the request, set err, tx_data=8'hEE, go to RD_STREAM (read) or WR_WAIT (write).
  - reg_addr still increments.
- Overrun: rx_valid while in WR_BUS or RD_BUS sets err and the byte is dropped; state is unchanged.
- Frame end: cs_active low in any state → IDLE next cycle.
  - reg_wr and reg_rd are cleared immediately; a late reg_ack is ignored.
  - byte_cnt holds its value until the next frame start.
- Simultaneous events:
  - cs_active fall together with rx_valid: frame end wins and the byte is discarded.
  - reg_ack together with timeout expiry: ack wins.
- err clears only on rst, or on a frame whose command byte is 8'hFF. That frame performs no bus access; the FSM stays in WR_WAIT and ignores data.
- byte_cnt counts every rx_valid accepted in a non-IDLE state and saturates at 8'hFF.

Decomposition:
- Shared package spi_pkg holds:
  - state encoding localparams;
  - the CMD_RW_BIT index;
  - CMD_CLEAR_ERR = 8'hFF;
  - ERR_BYTE = 8'hEE;
  - DATA_WIDTH default.
- One natural sub-module: spi_reg_bridge_timeout (loadable down-counter with an expire pulse), instantiated once.
- The FSM and datapath stay in the top module.

Test Plan:
- Write 3 bytes: frame {0x05, 0x11, 0x22, 0x33}, ack after 2 clk each → writes (0x05,0x11), (0x06,0x22), (0x07,0x33); byte_cnt=4; err=0.
- Read burst: frame {0x85, x, x}, reg_rdata = addr+0x40 → reg_rd at 0x05, 0x06, 0x07; tx_data 0x45 then 0x46; first tx_data at frame start = {0,0x2A}.
- Address wrap: write frame {0x7F, 0xAA, 0xBB} → writes at 0x7F then 0x00; err=0.
- Timeout: read frame {0x90}, reg_ack never asserted → reg_rd drops after 16 clk; err=1; tx_data=0xEE; next idle status byte=0xAA.
- Frame abort: cs_active drops while reg_wr is pending → reg_wr=0 next cycle, state IDLE; an ack 3 clk later has no effect. Then frame {0xFF} → err=0.
- Overrun and reset: rx_valid during RD_BUS → err=1, no extra bus access. rst asserted mid-frame → all outputs at reset values next cycle.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command decoder / register-bus bridge.
package spi_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int CMD_RW_BIT     = 7;
    localparam logic [7:0] CMD_CLEAR_ERR = 8'hFF;
    localparam logic [7:0] ERR_BYTE      = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CMD       = 3'd1,
        S_WR_WAIT   = 3'd2,
        S_WR_BUS    = 3'd3,
        S_RD_BUS    = 3'd4,
        S_RD_STREAM = 3'd5
    } state_t;

endpackage

// File: rtl/spi_reg_bridge_timeout.sv
// Bus-wait watchdog: reloads while idle, counts down while running, flags expiry.
module spi_reg_bridge_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Loaded with TIMEOUT-1 so expire rises in the TIMEOUT-th running cycle.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= CW'(TIMEOUT - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expire = !load && (cnt == '0);

endmodule

// File: rtl/spi_reg_bridge.sv
// Decodes SPI frames (command byte + data bytes) into register-bus reads/writes.
module spi_reg_bridge
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = 7,
    parameter int TIMEOUT    = 16,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ID = 7'h2A
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs_active,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_wr,
    output logic                  reg_rd,
    input  logic                  reg_ack,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  err,
    output logic [7:0]            byte_cnt
);

    state_t state;
    logic   cs_prev;
    logic   ign_data;
    logic   in_bus;
    logic   tmo_expire;

    assign in_bus = (state == S_WR_BUS) || (state == S_RD_BUS);

    spi_reg_bridge_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .load   (!in_bus),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cs_prev   <= 1'b0;
            ign_data  <= 1'b0;
            tx_data   <= {1'b0, STATUS_ID};
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            err       <= 1'b0;
            byte_cnt  <= '0;
        end else begin
            cs_prev <= cs_active;
            if (state != S_IDLE && !cs_active) begin
                // Frame end beats any byte or ack arriving in the same cycle.
                state  <= S_IDLE;
                reg_wr <= 1'b0;
                reg_rd <= 1'b0;
            end else begin
                if (state != S_IDLE && !in_bus && rx_valid && byte_cnt != 8'hFF)
                    byte_cnt <= byte_cnt + 8'd1;
                if (in_bus && rx_valid)
                    err <= 1'b1;
                case (state)
                    S_IDLE: begin
                        tx_data <= {err, STATUS_ID};
                        if (cs_active && !cs_prev) begin
                            state    <= S_CMD;
                            byte_cnt <= '0;
                            ign_data <= 1'b0;
                        end
                    end
                    S_CMD: if (rx_valid) begin
                        reg_addr <= rx_data[ADDR_WIDTH-1:0];
                        if (rx_data == CMD_CLEAR_ERR) begin
                            err      <= 1'b0;
                            ign_data <= 1'b1;
                            state    <= S_WR_WAIT;
                        end else if (rx_data[CMD_RW_BIT]) begin
                            reg_rd <= 1'b1;
                            state  <= S_RD_BUS;
                        end else begin
                            state <= S_WR_WAIT;
                        end
                    end
                    S_WR_WAIT: if (rx_valid && !ign_data) begin
                        reg_wdata <= rx_data;
                        reg_wr    <= 1'b1;
                        state     <= S_WR_BUS;
                    end
                    S_WR_BUS: if (reg_ack || tmo_expire) begin
                        reg_wr   <= 1'b0;
                        reg_addr <= reg_addr + ADDR_WIDTH'(1);
                        state    <= S_WR_WAIT;
                        if (!reg_ack) begin
                            err     <= 1'b1;
                            tx_data <= ERR_BYTE;
                        end
                    end
                    S_RD_BUS: if (reg_ack || tmo_expire) begin
                        reg_rd <= 1'b0;
                        state  <= S_RD_STREAM;
                        if (reg_ack) begin
                            tx_data <= reg_rdata;
                        end else begin
                            err      <= 1'b1;
                            tx_data  <= ERR_BYTE;
                            reg_addr <= reg_addr + ADDR_WIDTH'(1);
                        end
                    end
                    S_RD_STREAM: if (rx_valid) begin
                        reg_addr <= reg_addr + ADDR_WIDTH'(1);
                        reg_rd   <= 1'b1;
                        state    <= S_RD_BUS;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench: table of whole frames plus hand-written corner sequences.
module tb_spi_reg_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs_active;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic       reg_ack;
    logic [7:0] reg_rdata;
    logic       err;
    logic [7:0] byte_cnt;

    int n_vec = 0;
    int n_bad = 0;

    spi_reg_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .cs_active (cs_active),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_ack   (reg_ack),
        .reg_rdata (reg_rdata),
        .err       (err),
        .byte_cnt  (byte_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [3:0][7:0] b;     // frame bytes, [0] is the command
        int              nb;
        logic [3:0]      acc;   // byte index that triggers a bus access
        logic [3:0][6:0] addr;  // expected bus address per access
        logic [3:0][7:0] dat;   // expected wdata (write) or tx_data (read)
        logic [7:0]      cnt;
    } vec_t;

    vec_t tbl [4];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic start_frame();
        cs_active = 1'b1;
        tick();
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        logic is_rd;
        is_rd = v.b[0][7];
        start_frame();
        chk({v.name, " tx_start"}, tx_data, 8'h2A);
        for (int i = 0; i < v.nb; i++) begin
            send_byte(v.b[i]);
            if (v.acc[i]) begin
                chk($sformatf("%s req%0d", v.name, i), {reg_wr, reg_rd}, is_rd ? 2'b01 : 2'b10);
                chk($sformatf("%s addr%0d", v.name, i), reg_addr, v.addr[i]);
                if (!is_rd) chk($sformatf("%s wdata%0d", v.name, i), reg_wdata, v.dat[i]);
                tick();
                reg_ack   = 1'b1;
                reg_rdata = {1'b0, reg_addr} + 8'h40;
                tick();
                reg_ack = 1'b0;
                chk($sformatf("%s drop%0d", v.name, i), {reg_wr, reg_rd}, 2'b00);
                if (is_rd) chk($sformatf("%s tx%0d", v.name, i), tx_data, v.dat[i]);
            end
            tick();
        end
        cs_active = 1'b0;
        tick();
        chk({v.name, " byte_cnt"}, byte_cnt, v.cnt);
        chk({v.name, " err"}, err, 1'b0);
        tick();
    endtask

    initial begin
        int n;
        rst = 1'b1; cs_active = 1'b0; rx_data = '0; rx_valid = 1'b0;
        reg_ack = 1'b0; reg_rdata = '0;

        tbl[0] = '{"wr3",  {8'h33, 8'h22, 8'h11, 8'h05}, 4, 4'b1110,
                   {7'h07, 7'h06, 7'h05, 7'h00}, {8'h33, 8'h22, 8'h11, 8'h00}, 8'd4};
        tbl[1] = '{"rd3",  {8'h00, 8'h00, 8'h00, 8'h85}, 3, 4'b0111,
                   {7'h00, 7'h07, 7'h06, 7'h05}, {8'h00, 8'h47, 8'h46, 8'h45}, 8'd3};
        tbl[2] = '{"wrap", {8'h00, 8'hBB, 8'hAA, 8'h7F}, 3, 4'b0110,
                   {7'h00, 7'h00, 7'h7F, 7'h00}, {8'h00, 8'hBB, 8'hAA, 8'h00}, 8'd3};
        tbl[3] = '{"rdwrap", {8'h00, 8'h00, 8'h00, 8'hFE}, 2, 4'b0011,
                   {7'h00, 7'h00, 7'h7F, 7'h7E}, {8'h00, 8'h00, 8'hBF, 8'hBE}, 8'd2};

        tick(); tick();
        chk("rst tx_data", tx_data, 8'h2A);
        chk("rst addr", reg_addr, 7'h00);
        chk("rst wdata", reg_wdata, 8'h00);
        chk("rst req", {reg_wr, reg_rd}, 2'b00);
        chk("rst err", err, 1'b0);
        chk("rst byte_cnt", byte_cnt, 8'h00);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) run_vec(tbl[i]);

        // Timeout on a read that is never acknowledged.
        start_frame();
        send_byte(8'h90);
        chk("tmo req", reg_rd, 1'b1);
        chk("tmo addr", reg_addr, 7'h10);
        n = 1;
        while (reg_rd && n < 100) begin
            tick();
            if (reg_rd) n++;
        end
        chk("tmo rd_cycles", n, 16);
        chk("tmo err", err, 1'b1);
        chk("tmo tx_data", tx_data, 8'hEE);
        chk("tmo addr_inc", reg_addr, 7'h11);
        cs_active = 1'b0;
        tick(); tick();
        chk("tmo idle_status", tx_data, 8'hAA);

        // Frame abort with a write pending, then a late ack.
        start_frame();
        send_byte(8'h20);
        tick(); tick();
        send_byte(8'h55);
        chk("abort wr_req", reg_wr, 1'b1);
        cs_active = 1'b0;
        tick();
        chk("abort wr_drop", reg_wr, 1'b0);
        tick(); tick();
        reg_ack = 1'b1;
        tick();
        reg_ack = 1'b0;
        tick();
        chk("abort late_ack addr", reg_addr, 7'h20);
        chk("abort late_ack req", {reg_wr, reg_rd}, 2'b00);

        // Clear-error frame ignores its data.
        start_frame();
        send_byte(8'hFF);
        tick();
        chk("clr err", err, 1'b0);
        send_byte(8'h12);
        chk("clr no_access", {reg_wr, reg_rd}, 2'b00);
        tick(); tick();
        cs_active = 1'b0;
        tick(); tick();
        chk("clr status", tx_data, 8'h2A);
        chk("clr byte_cnt", byte_cnt, 8'd2);

        // Overrun: byte arrives while a read is outstanding.
        start_frame();
        send_byte(8'h83);
        chk("ovr req", reg_rd, 1'b1);
        send_byte(8'h00);
        chk("ovr err", err, 1'b1);
        chk("ovr still_rd", reg_rd, 1'b1);
        chk("ovr addr", reg_addr, 7'h03);
        reg_ack = 1'b1;
        reg_rdata = 8'h43;
        tick();
        reg_ack = 1'b0;
        chk("ovr tx", tx_data, 8'h43);
        tick(); tick(); tick();
        chk("ovr no_extra", {reg_wr, reg_rd}, 2'b00);
        send_byte(8'h00);
        chk("ovr next_rd", reg_rd, 1'b1);
        chk("ovr next_addr", reg_addr, 7'h04);

        // Reset mid-frame.
        rst = 1'b1;
        tick();
        chk("mrst tx", tx_data, 8'h2A);
        chk("mrst addr", reg_addr, 7'h00);
        chk("mrst wdata", reg_wdata, 8'h00);
        chk("mrst req", {reg_wr, reg_rd}, 2'b00);
        chk("mrst err", err, 1'b0);
        chk("mrst byte_cnt", byte_cnt, 8'h00);
        rst = 1'b0;
        cs_active = 1'b0;
        tick();

        // Frame end together with a data byte: the byte is discarded.
        start_frame();
        send_byte(8'h30);
        tick();
        cs_active = 1'b0;
        send_byte(8'h99);
        chk("endrx req", reg_wr, 1'b0);
        chk("endrx wdata", reg_wdata, 8'h00);
        chk("endrx byte_cnt", byte_cnt, 8'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
